// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes, RAM port and status between clients and the arbiter
interface ram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          req0, we0, ack0;
  logic          req1, we1, ack1;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [DW-1:0] wdata0, rdata0, wdata1, rdata1;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we, busy;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    output ack0, rdata0, ack1, rdata1, ram_addr, ram_we, ram_din, busy
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    input  ack0, rdata0, ack1, rdata1, ram_addr, ram_we, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin sequencer in front of a single-port synchronous RAM
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1
) (
  input logic            clk,
  input logic            rst,
  ram_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t                r_state;
  logic                  r_last, r_gid, r_we_sel, r_ram_we, r_busy;
  logic                  r_ack0, r_ack1;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din, r_rdata0, r_rdata1;
  logic                  w_gid, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  // contention goes to whoever was not granted last
  assign w_gid   = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_we    = w_gid ? bus.we1 : bus.we0;
  assign w_addr  = w_gid ? bus.addr1 : bus.addr0;
  assign w_wdata = w_gid ? bus.wdata1 : bus.wdata0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_gid      <= 1'b0;
      r_we_sel   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_cnt      <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req0 | bus.req1) begin
          r_state    <= ACCESS;
          r_busy     <= 1'b1;
          r_gid      <= w_gid;
          r_last     <= w_gid;
          r_we_sel   <= w_we;
          r_ram_we   <= w_we;
          r_ram_addr <= w_addr;
          r_ram_din  <= w_wdata;
        end
        ACCESS: begin
          r_state  <= WAIT;
          r_ram_we <= 1'b0;
          r_cnt    <= 3'(RD_LAT - 1);
        end
        WAIT: if (r_cnt == '0) begin
          r_state <= ACK;
          r_ack0  <= ~r_gid;
          r_ack1  <= r_gid;
          if (!r_we_sel && !r_gid) r_rdata0 <= bus.ram_dout;
          if (!r_we_sel && r_gid)  r_rdata1 <= bus.ram_dout;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_we   = r_ram_we;
  assign bus.ram_din  = r_ram_din;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with RAM models at read latency 1 and 3
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_if #(.DW(32), .AW(10)) b1 ();
  ram_arbiter_if #(.DW(32), .AW(10)) b3 ();
  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  function automatic logic [31:0] init_val(input int i);
    return (i == 13) ? 32'h0000_00AA : (32'hC0DE_0000 | 32'(i));
  endfunction
  logic [31:0] m1 [1024];
  logic [31:0] m3 [1024];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) m1[i] <= init_val(i);
      p1 <= '0;
    end else begin
      if (b1.ram_we) m1[b1.ram_addr] <= b1.ram_din;
      p1 <= m1[b1.ram_addr];
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) m3[i] <= init_val(i);
      for (int i = 0; i < 3; i++) p3[i] <= '0;
    end else begin
      if (b3.ram_we) m3[b3.ram_addr] <= b3.ram_din;
      p3[0] <= m3[b3.ram_addr];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign b1.ram_dout = p1;
  assign b3.ram_dout = p3[2];
  typedef struct {
    int          g;
    logic        we;
    logic [31:0] d;
  } exp_t;
  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] sh [1024];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int we_cnt  = 0;
  int w0, a0, a1, a2, a3, t, n;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (b1.ram_we) we_cnt <= we_cnt + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic reset_shadow();
    for (int i = 0; i < 1024; i++) sh[i] = init_val(i);
  endtask
  task automatic expect_op(input int g, input logic we, input int a, input logic [31:0] d);
    if (we) sh[a] = d;
    sbq.push_back('{g: g, we: we, d: sh[a]});
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.ack0 && b1.ack1) chk("dual_ack", 64'd1, 64'd0);
      else if (b1.ack0 || b1.ack1) begin
        if (sbq.size() == 0) chk("unexpected_ack", {63'd0, b1.ack1}, 64'hDEAD);
        else begin
          mon_e = sbq.pop_front();
          chk("ack_gid", {63'd0, b1.ack1}, 64'(mon_e.g));
          if (!mon_e.we) chk("rdata", {32'd0, b1.ack1 ? b1.rdata1 : b1.rdata0}, {32'd0, mon_e.d});
        end
      end
    end
  end
  task automatic wait_ack(input int g, output int cnt);
    bit got = 0;
    for (cnt = 1; cnt <= 40; cnt++) begin
      @(negedge clk);
      if (g == 0 ? b1.ack0 : b1.ack1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("ack_timeout", 64'd0, 64'd1);
      cnt = 0;
    end
  endtask
  task automatic run(input int g, input logic we, input logic [9:0] a, input logic [31:0] d,
                     input int lat, output int ack_cyc);
    int k;
    if (g == 0) begin
      b1.req0 = 1'b1; b1.we0 = we; b1.addr0 = a; b1.wdata0 = d;
    end else begin
      b1.req1 = 1'b1; b1.we1 = we; b1.addr1 = a; b1.wdata1 = d;
    end
    wait_ack(g, k);
    ack_cyc = cyc;
    if (lat > 0 && k > 0) chk("latency", 64'(k), 64'(lat));
  endtask
  task automatic rel(input int g);
    if (g == 0) b1.req0 = 1'b0;
    else b1.req1 = 1'b0;
  endtask
  initial begin
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = '0; b1.wdata0 = '0;
    b1.req1 = 0; b1.we1 = 0; b1.addr1 = '0; b1.wdata1 = '0;
    b3.req0 = 0; b3.we0 = 0; b3.addr0 = '0; b3.wdata0 = '0;
    b3.req1 = 0; b3.we1 = 0; b3.addr1 = '0; b3.wdata1 = '0;
    reset_shadow();
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, b1.busy}, 64'd0);
    chk("rst_ram_we", {63'd0, b1.ram_we}, 64'd0);
    chk("rst_ack", {62'd0, b1.ack1, b1.ack0}, 64'd0);
    chk("rst_rdata", {b1.rdata1, b1.rdata0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    w0 = we_cnt;
    expect_op(0, 1'b0, 13, 32'd0);
    run(0, 1'b0, 10'd13, 32'h5555_5555, 3, t);
    rel(0);
    @(negedge clk);
    chk("t1_busy_after", {63'd0, b1.busy}, 64'd0);
    chk("t1_no_we", 64'(we_cnt - w0), 64'd0);
    w0 = we_cnt;
    expect_op(1, 1'b1, 13, 32'hFA07_F111);
    run(1, 1'b1, 10'd13, 32'hFA07_F111, 3, t);
    rel(1);
    @(negedge clk);
    chk("t2_we_pulses", 64'(we_cnt - w0), 64'd1);
    expect_op(1, 1'b0, 13, 32'd0);
    run(1, 1'b0, 10'd13, 32'd0, 3, t);
    rel(1);
    @(negedge clk);
    expect_op(0, 1'b0, 16, 32'd0);
    expect_op(1, 1'b0, 32, 32'd0);
    expect_op(0, 1'b0, 48, 32'd0);
    expect_op(1, 1'b0, 64, 32'd0);
    fork
      begin run(0, 1'b0, 10'd16, 32'd0, 0, a0); run(0, 1'b0, 10'd48, 32'd0, 0, a2); rel(0); end
      begin run(1, 1'b0, 10'd32, 32'd0, 0, a1); run(1, 1'b0, 10'd64, 32'd0, 0, a3); rel(1); end
    join
    chk("t3_space01", 64'(a1 - a0), 64'd4);
    chk("t3_space12", 64'(a2 - a1), 64'd4);
    chk("t3_space23", 64'(a3 - a2), 64'd4);
    @(negedge clk);
    expect_op(0, 1'b0, 100, 32'd0);
    b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = 10'd100;
    @(negedge clk);
    chk("t6_busy_access", {63'd0, b1.busy}, 64'd1);
    b1.req0 = 1'b0; b1.addr0 = 10'd7;
    wait_ack(0, n);
    chk("t6_ack_lat", 64'(n), 64'd2);
    @(negedge clk);
    chk("t6_busy_idle", {63'd0, b1.busy}, 64'd0);
    chk("t6_ack_single", {63'd0, b1.ack0}, 64'd0);
    b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 10'd200; b1.wdata1 = 32'h1234_5678;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_busy", {63'd0, b1.busy}, 64'd0);
    chk("t4_ram_addr", 64'(b1.ram_addr), 64'd0);
    chk("t4_ram_din", {32'd0, b1.ram_din}, 64'd0);
    chk("t4_ram_we", {63'd0, b1.ram_we}, 64'd0);
    chk("t4_ack", {62'd0, b1.ack1, b1.ack0}, 64'd0);
    chk("t4_rdata", {b1.rdata1, b1.rdata0}, 64'd0);
    b1.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_shadow();
    @(negedge clk);
    expect_op(0, 1'b0, 5, 32'd0);
    expect_op(1, 1'b0, 6, 32'd0);
    fork
      begin run(0, 1'b0, 10'd5, 32'd0, 3, a0); rel(0); end
      begin run(1, 1'b0, 10'd6, 32'd0, 0, a1); rel(1); end
    join
    chk("t4_order", 64'(a1 - a0), 64'd4);
    b3.req0 = 1'b1; b3.we0 = 1'b0; b3.addr0 = 10'd13;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b3.ack0) begin n = k; break; end
    end
    chk("t5_lat", 64'(n), 64'd5);
    chk("t5_rdata", {32'd0, b3.rdata0}, {32'd0, init_val(13)});
    b3.addr0 = 10'd16;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b3.ack0) begin n = k; break; end
    end
    b3.req0 = 1'b0;
    chk("t5_period", 64'(n), 64'd6);
    chk("t5_rdata2", {32'd0, b3.rdata0}, {32'd0, init_val(16)});
    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
